// File: rtl/encoder_proj_pkg.sv
// rtl/encoder_proj_pkg.sv - shared state encoding and Hamming(7,4) helpers for the encoder link
package encoder_proj_pkg;

  localparam int CW_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  // Codeword bit i carries Hamming position i+1: {d4, d3, d2, p4, d1, p2, p1}.
  function automatic logic [CW_W-1:0] ham74_enc(input logic [3:0] nib);
    logic p1, p2, p4;
    p1 = nib[0] ^ nib[1] ^ nib[3];
    p2 = nib[0] ^ nib[2] ^ nib[3];
    p4 = nib[1] ^ nib[2] ^ nib[3];
    return {nib[3], nib[2], nib[1], p4, nib[0], p2, p1};
  endfunction

  function automatic logic [CW_W-1:0] inj_mask(input logic [2:0] pos);
    return (pos == 3'd0) ? '0 : (CW_W'(1) << (pos - 3'd1));
  endfunction

endpackage

// File: rtl/encoder_proj_fifo.sv
// rtl/encoder_proj_fifo.sv - DEPTH x 8 synchronous byte FIFO with wrap-bit full/empty detection
module encoder_proj_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/encoder_proj.sv
// rtl/encoder_proj.sv - byte-to-Hamming(7,4) codeword transmitter with FIFO, error injection and counter
module encoder_proj
  import encoder_proj_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CW_W-1:0]  io_out,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  input  logic [2:0]       inj_pos,
  output logic [CNT_W-1:0] cw_count
);

  state_t     state;
  logic [3:0] hold_hi;
  logic [7:0] fifo_dout;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       fire;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign fire     = io_out_valid && io_out_ready;
  // HI pops the next byte on the same handshake so back-to-back bytes leave no bubble.
  assign pop      = !empty && ((state == IDLE) || ((state == HI) && io_out_ready));

  encoder_proj_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    (in_data),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold_hi      <= '0;
      io_out       <= '0;
      io_out_valid <= 1'b0;
      cw_count     <= '0;
    end else begin
      if (fire) cw_count <= cw_count + CNT_W'(1);
      case (state)
        IDLE: begin
          if (!empty) begin
            hold_hi      <= fifo_dout[7:4];
            io_out       <= ham74_enc(fifo_dout[3:0]) ^ inj_mask(inj_pos);
            io_out_valid <= 1'b1;
            state        <= LO;
          end
        end
        LO: begin
          if (io_out_ready) begin
            io_out <= ham74_enc(hold_hi) ^ inj_mask(inj_pos);
            state  <= HI;
          end
        end
        HI: begin
          if (io_out_ready) begin
            if (!empty) begin
              hold_hi <= fifo_dout[7:4];
              io_out  <= ham74_enc(fifo_dout[3:0]) ^ inj_mask(inj_pos);
              state   <= LO;
            end else begin
              io_out_valid <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: begin
          io_out_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_proj.sv
// tb/tb_encoder_proj.sv - randomized self-checking bench for encoder_proj against a Hamming reference model
module tb_encoder_proj;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  io_out;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [2:0]  inj_pos;
  logic [15:0] cw_count;

  logic        in_ready2;
  logic [6:0]  io_out2;
  logic        io_out_valid2;
  logic [1:0]  cw_count2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_cnt  = 0;
  int n_pushed = 0;
  logic [6:0] exp_q[$];
  logic [6:0] seen_q[$];
  int         fire_cyc[$];

  encoder_proj #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .io_out      (io_out),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .inj_pos     (inj_pos),
    .cw_count    (cw_count)
  );

  encoder_proj #(.DEPTH(DEPTH), .CNT_W(2)) u_dut_w2 (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready2),
    .io_out      (io_out2),
    .io_out_valid(io_out_valid2),
    .io_out_ready(io_out_ready),
    .inj_pos     (inj_pos),
    .cw_count    (cw_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Generic Hamming: data at non-power-of-two positions, parity 2^j covers positions with bit j set.
  function automatic logic [6:0] ref_enc(input logic [3:0] nib, input logic [2:0] inj);
    logic [6:0] cw;
    int dpos [4];
    logic par;
    dpos[0] = 3; dpos[1] = 5; dpos[2] = 6; dpos[3] = 7;
    cw = '0;
    for (int i = 0; i < 4; i++) cw[dpos[i]-1] = nib[i];
    for (int j = 0; j < 3; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 7; p++)
        if (((p >> j) & 1) == 1 && p != (1 << j)) par = par ^ cw[p-1];
      cw[(1 << j) - 1] = par;
    end
    if (inj != 3'd0) cw[inj-1] = ~cw[inj-1];
    return cw;
  endfunction

  function automatic logic [3:0] ref_dec(input logic [6:0] cw_in);
    logic [6:0] cw;
    int syn;
    cw  = cw_in;
    syn = 0;
    for (int p = 1; p <= 7; p++) if (cw[p-1]) syn = syn ^ p;
    if (syn != 0) cw[syn-1] = ~cw[syn-1];
    return {cw[6], cw[5], cw[4], cw[2]};
  endfunction

  // Called at a falling edge with inputs already set; advances one clock.
  task automatic tick();
    logic       held_v;
    logic [6:0] held;
    logic [6:0] exp_cw;
    held_v = io_out_valid && !io_out_ready;
    held   = io_out;
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_enc(in_data[3:0], inj_pos));
      exp_q.push_back(ref_enc(in_data[7:4], inj_pos));
      n_pushed++;
    end
    if (io_out_valid && io_out_ready) begin
      check("spurious_cw", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_cw = exp_q.pop_front();
        check("codeword", 32'(io_out), 32'(exp_cw));
        check("codeword_w2", 32'(io_out2), 32'(exp_cw));
      end
      seen_q.push_back(io_out);
      fire_cyc.push_back(cyc);
      exp_cnt++;
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
    if (held_v) begin
      check("hold_valid", 32'(io_out_valid), 32'd1);
      check("hold_data", 32'(io_out), 32'(held));
    end
    check("cw_count", 32'(cw_count), 32'(exp_cnt % 65536));
    check("cw_count_w2", 32'(cw_count2), 32'(exp_cnt % 4));
  endtask

  task automatic drain();
    int budget;
    in_valid     = 1'b0;
    io_out_ready = 1'b1;
    budget       = 0;
    while ((exp_q.size() != 0 || io_out_valid) && budget < 100) begin
      tick();
      budget++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !io_out_valid), 32'd1);
  endtask

  task automatic clear_logs();
    seen_q.delete();
    fire_cyc.delete();
  endtask

  initial begin
    reset_n      = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    io_out_ready = 1'b0;
    inj_pos      = 3'd0;
    repeat (2) @(negedge clock);
    check("rst_valid", 32'(io_out_valid), 32'd0);
    check("rst_io_out", 32'(io_out), 32'd0);
    check("rst_count", 32'(cw_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clock);

    // Single byte, latency and literal codewords
    clear_logs();
    io_out_ready = 1'b1;
    in_data      = 8'hB1;
    in_valid     = 1'b1;
    tick();
    in_valid = 1'b0;
    check("latency_pre", 32'(io_out_valid), 32'd0);
    tick();
    check("latency_post", 32'(io_out_valid), 32'd1);
    drain();
    check("t1_ncw", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() >= 2) begin
      check("t1_lo", 32'(seen_q[0]), 32'b0000111);
      check("t1_hi", 32'(seen_q[1]), 32'b1010101);
    end
    check("t1_count", 32'(cw_count), 32'd2);
    check("t1_idle", 32'(io_out_valid), 32'd0);

    // Back-to-back bytes without a bubble
    clear_logs();
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    in_data = 8'hFF;
    tick();
    drain();
    check("t2_ncw", 32'(seen_q.size()), 32'd4);
    if (seen_q.size() >= 4) begin
      check("t2_cw0", 32'(seen_q[0]), 32'h00);
      check("t2_cw1", 32'(seen_q[1]), 32'h00);
      check("t2_cw2", 32'(seen_q[2]), 32'h7F);
      check("t2_cw3", 32'(seen_q[3]), 32'h7F);
      check("t2_nobubble", 32'(fire_cyc[3] - fire_cyc[0]), 32'd3);
    end

    // Backpressure until full, then release
    clear_logs();
    io_out_ready = 1'b0;
    n_pushed     = 0;
    in_valid     = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    check("t3_full", 32'(in_ready), 32'd0);
    check("t3_full_w2", 32'(in_ready2), 32'd0);
    check("t3_accepted", 32'(n_pushed), 32'(DEPTH + 1));
    in_valid = 1'b0;
    repeat (3) tick();
    drain();
    check("t3_ncw", 32'(seen_q.size()), 32'(2 * (DEPTH + 1)));

    // Error injection at position 3
    clear_logs();
    inj_pos  = 3'd3;
    in_data  = 8'h01;
    in_valid = 1'b1;
    tick();
    drain();
    inj_pos = 3'd0;
    check("t4_ncw", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() >= 2) begin
      check("t4_lo", 32'(seen_q[0]), 32'b0000011);
      check("t4_hi", 32'(seen_q[1]), 32'b0000100);
      check("t4_dec_lo", 32'(ref_dec(seen_q[0])), 32'h1);
      check("t4_dec_hi", 32'(ref_dec(seen_q[1])), 32'h0);
    end

    // Reset while the low nibble of 0xB1 is on the output
    io_out_ready = 1'b0;
    in_data      = 8'hB1;
    in_valid     = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t5_in_lo", 32'(io_out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_valid", 32'(io_out_valid), 32'd0);
    check("t5_io_out", 32'(io_out), 32'd0);
    check("t5_count", 32'(cw_count), 32'd0);
    check("t5_count_w2", 32'(cw_count2), 32'd0);
    check("t5_valid_w2", 32'(io_out_valid2), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clock);
    reset_n      = 1'b1;
    io_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_no_resume", 32'(io_out_valid), 32'd0);
    end

    // Narrow counter wraps 3 -> 0 -> 1 -> 2 over three bytes
    clear_logs();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    drain();
    check("t6_count_w2", 32'(cw_count2), 32'd2);
    check("t6_count", 32'(cw_count), 32'd6);

    // Randomized traffic with random backpressure and injection
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !io_out_valid && ($urandom % 4) == 0)
        inj_pos = 3'($urandom_range(0, 7));
      in_valid     = 1'($urandom % 2);
      in_data      = 8'($urandom);
      io_out_ready = (($urandom % 4) != 0);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
